// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front-end: channel FSM states, button
// indices and default timing constants.
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDbPress,
        StPressed,
        StHeld,
        StDbRel
    } btn_state_e;

    localparam int unsigned BTN_MODE       = 0;
    localparam int unsigned BTN_RESET      = 1;
    localparam int unsigned BTN_START_STOP = 2;
    localparam int unsigned BTN_EDIT_SHIFT = 3;
    localparam int unsigned BTN_INC        = 4;

    localparam int unsigned DEF_N_BTN        = 5;
    localparam int unsigned DEF_DEBOUNCE_CYC = 1_000_000;
    localparam int unsigned DEF_LONG_CYC     = 100_000_000;
    localparam int unsigned DEF_REPEAT_CYC   = 20_000_000;
    localparam logic [4:0]  DEF_REPEAT_MASK  = 5'(1 << BTN_INC);

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM and hold/repeat counters.
// All outputs are registered one-cycle pulses except the debounced level.
module button_conditioner_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter int unsigned CNT_W        = 27,
    parameter bit          REPEAT_EN    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic             sync_q1;
    logic             sync_q2;
    btn_state_e       state_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] rcnt_q;
    logic             long_flag_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q1       <= 1'b0;
            sync_q2       <= 1'b0;
            state_q       <= StIdle;
            dcnt_q        <= '0;
            hcnt_q        <= '0;
            rcnt_q        <= '0;
            long_flag_q   <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            sync_q1       <= btn_raw;
            sync_q2       <= sync_q1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (sync_q2) begin
                        state_q <= StDbPress;
                        dcnt_q  <= '0;
                    end
                end
                StDbPress: begin
                    if (!sync_q2) begin
                        state_q <= StIdle;
                    end else if (dcnt_q == DB_LAST) begin
                        state_q     <= StPressed;
                        press_pulse <= 1'b1;
                        level       <= 1'b1;
                        hcnt_q      <= '0;
                        long_flag_q <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                StPressed: begin
                    // hcnt stops at its terminal value: the state leaves PRESSED there.
                    if (hcnt_q == LONG_LAST) begin
                        state_q     <= StHeld;
                        long_pulse  <= 1'b1;
                        long_flag_q <= 1'b1;
                        rcnt_q      <= '0;
                    end else begin
                        hcnt_q <= hcnt_q + 1'b1;
                        if (!sync_q2) begin
                            state_q <= StDbRel;
                            dcnt_q  <= '0;
                        end
                    end
                end
                StHeld: begin
                    if (rcnt_q == REP_LAST) begin
                        rcnt_q       <= '0;
                        repeat_pulse <= REPEAT_EN;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                    if (!sync_q2) begin
                        state_q <= StDbRel;
                        dcnt_q  <= '0;
                    end
                end
                StDbRel: begin
                    // hcnt/rcnt hold here so a glitch only delays long/repeat timing.
                    if (sync_q2) begin
                        state_q <= long_flag_q ? StHeld : StPressed;
                    end else if (dcnt_q == DB_LAST) begin
                        state_q       <= StIdle;
                        release_pulse <= 1'b1;
                        level         <= 1'b0;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front-end: one independent synchronise/debounce/event channel per
// button, producing press, release, long-press and auto-repeat pulses.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned          N_BTN        = DEF_N_BTN,
    parameter int unsigned          DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int unsigned          LONG_CYC     = DEF_LONG_CYC,
    parameter int unsigned          REPEAT_CYC   = DEF_REPEAT_CYC,
    parameter logic [N_BTN-1:0]     REPEAT_MASK  = DEF_REPEAT_MASK
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int unsigned CNT_W = $clog2(max3(DEBOUNCE_CYC, LONG_CYC, REPEAT_CYC));

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        button_conditioner_channel #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC),
            .CNT_W        (CNT_W),
            .REPEAT_EN    (REPEAT_MASK[i])
        ) u_chan (
            .clk           (clk),
            .reset_n       (reset_n),
            .btn_raw       (btn_in[i]),
            .level         (btn_level[i]),
            .press_pulse   (btn_press[i]),
            .release_pulse (btn_release[i]),
            .long_pulse    (btn_long[i]),
            .repeat_pulse  (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with short timing constants; edge n is the
// n-th clock edge after reset release, edge 1 samples the first high input.
module tb_button_conditioner;

    localparam int unsigned N_BTN = 5;

    logic             clk;
    logic             reset_n;
    logic [N_BTN-1:0] btn_in;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;
    logic [N_BTN-1:0] btn_repeat;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .N_BTN        (N_BTN),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .REPEAT_CYC   (5),
        .REPEAT_MASK  (5'b10000)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long),
        .btn_repeat  (btn_repeat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int hold;
        int g_start;
        int g_len;
        int exp_press;
        int exp_long;
        int exp_release;
        int exp_rpt_cnt;
        int exp_rpt_first;
        int exp_rpt_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        btn_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int press_first = 0, press_cnt = 0, long_first = 0, long_cnt = 0;
        int rel_first = 0, rel_cnt = 0, rpt_cnt = 0, rpt_first = 0, rpt_last = 0;
        int others = 0;
        logic lvl_at_press = 1'b0;
        do_reset();
        for (int n = 1; n <= v.hold + 15; n++) begin
            btn_in = '0;
            if (n <= v.hold && !(n >= v.g_start && n < v.g_start + v.g_len))
                btn_in[v.ch] = 1'b1;
            @(posedge clk);
            #1;
            if (btn_press[v.ch]) begin
                press_cnt++;
                if (press_first == 0) begin
                    press_first  = n;
                    lvl_at_press = btn_level[v.ch];
                end
            end
            if (btn_long[v.ch]) begin
                long_cnt++;
                if (long_first == 0) long_first = n;
            end
            if (btn_release[v.ch]) begin
                rel_cnt++;
                if (rel_first == 0) rel_first = n;
            end
            if (btn_repeat[v.ch]) begin
                rpt_cnt++;
                if (rpt_first == 0) rpt_first = n;
                rpt_last = n;
            end
            for (int c = 0; c < N_BTN; c++)
                if (c != v.ch && (btn_level[c] | btn_press[c] | btn_release[c] |
                                  btn_long[c] | btn_repeat[c]))
                    others++;
        end
        check($sformatf("v%0d press_edge", idx), press_first, v.exp_press);
        check($sformatf("v%0d press_cnt", idx), press_cnt, (v.exp_press != 0) ? 1 : 0);
        check($sformatf("v%0d level_at_press", idx), {31'd0, lvl_at_press},
              (v.exp_press != 0) ? 1 : 0);
        check($sformatf("v%0d long_edge", idx), long_first, v.exp_long);
        check($sformatf("v%0d long_cnt", idx), long_cnt, (v.exp_long != 0) ? 1 : 0);
        check($sformatf("v%0d release_edge", idx), rel_first, v.exp_release);
        check($sformatf("v%0d release_cnt", idx), rel_cnt, (v.exp_release != 0) ? 1 : 0);
        check($sformatf("v%0d repeat_cnt", idx), rpt_cnt, v.exp_rpt_cnt);
        check($sformatf("v%0d repeat_first", idx), rpt_first, v.exp_rpt_first);
        check($sformatf("v%0d repeat_last", idx), rpt_last, v.exp_rpt_last);
        check($sformatf("v%0d other_channels", idx), others, 0);
        check($sformatf("v%0d level_final", idx), {31'd0, btn_level[v.ch]}, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   evt_cnt, lvl_seen, both_press, both_rel, press_first, rel_cnt, long_first;

        //          ch hold gs gl  press long rel  rpts first last
        vecs[0] = '{0, 15,  0, 0,  7,    0,   22,  0,   0,    0};
        vecs[1] = '{4, 60,  0, 0,  7,    27,  67,  7,   32,   62};
        vecs[2] = '{0, 60,  0, 0,  7,    27,  67,  0,   0,    0};
        vecs[3] = '{0, 40, 12, 2,  7,    29,  47,  0,   0,    0};
        vecs[4] = '{3, 50, 20, 4,  7,    31,  57,  0,   0,    0};
        vecs[5] = '{1, 4,   0, 0,  0,    0,   0,   0,   0,    0};
        vecs[6] = '{1, 5,   0, 0,  7,    0,   12,  0,   0,    0};

        // Reset state
        reset_n = 1'b0;
        btn_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset level",   btn_level,   0);
        check("reset press",   btn_press,   0);
        check("reset release", btn_release, 0);
        check("reset long",    btn_long,    0);
        check("reset repeat",  btn_repeat,  0);

        for (int i = 0; i < 7; i++) run_vector(i, vecs[i]);

        // Bounce on start_stop: 2-cycle toggles never reach the debounce threshold
        do_reset();
        evt_cnt  = 0;
        lvl_seen = 0;
        for (int n = 1; n <= 30; n++) begin
            btn_in = '0;
            if (n <= 12 && ((n - 1) / 2) % 2 == 0) btn_in[2] = 1'b1;
            @(posedge clk);
            #1;
            if (|{btn_press, btn_release, btn_long, btn_repeat}) evt_cnt++;
            if (|btn_level) lvl_seen++;
        end
        check("bounce events", evt_cnt, 0);
        check("bounce level", lvl_seen, 0);

        // mode and edit_shift pressed together
        do_reset();
        both_press = 0;
        both_rel   = 0;
        for (int n = 1; n <= 25; n++) begin
            btn_in = (n <= 10) ? 5'b01001 : 5'b00000;
            @(posedge clk);
            #1;
            if (btn_press == 5'b01001 && both_press == 0) both_press = n;
            if (btn_release == 5'b01001 && both_rel == 0) both_rel = n;
        end
        check("simul press_edge", both_press, 7);
        check("simul release_edge", both_rel, 17);

        // Reset while inc is in HELD, button still held through deassertion
        do_reset();
        long_first = 0;
        for (int n = 1; n <= 35; n++) begin
            btn_in = 5'b10000;
            @(posedge clk);
            #1;
            if (btn_long[4] && long_first == 0) long_first = n;
        end
        check("rst_held long_edge", long_first, 27);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_held level",   btn_level,   0);
        check("rst_held press",   btn_press,   0);
        check("rst_held release", btn_release, 0);
        check("rst_held long",    btn_long,    0);
        check("rst_held repeat",  btn_repeat,  0);
        @(posedge clk);
        #1;
        rel_cnt = (btn_release != 0 || btn_repeat != 0) ? 1 : 0;
        reset_n = 1'b1;
        press_first = 0;
        long_first  = 0;
        for (int n = 38; n <= 52; n++) begin
            @(posedge clk);
            #1;
            if (btn_press[4] && press_first == 0) press_first = n;
            if (btn_release != 0) rel_cnt++;
            if (btn_long != 0) long_first = n;
        end
        check("rst_held repress_edge", press_first, 44);
        check("rst_held no_release", rel_cnt, 0);
        check("rst_held no_long", long_first, 0);
        check("rst_held level_final", btn_level, 5'b10000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
